// File: rtl/bp_pkg.sv
// Shared types and saturating-counter helpers for the gshare/BTB branch predictor.
package bp_pkg;

    localparam int BP_XLEN   = 32;
    localparam int CNT_MAX_W = 8;

    // Read view of one BTB slot; narrower tags are zero-extended into the field.
    typedef struct packed {
        logic               valid;
        logic [BP_XLEN-1:0] tag;
        logic [BP_XLEN-1:0] target;
    } btb_entry_t;

    function automatic logic [CNT_MAX_W-1:0] cnt_max(input int unsigned cnt_w);
        return CNT_MAX_W'((64'd1 << cnt_w) - 64'd1);
    endfunction

    function automatic logic [CNT_MAX_W-1:0] sat_inc(input logic [CNT_MAX_W-1:0] cnt,
                                                     input int unsigned cnt_w);
        return (cnt >= cnt_max(cnt_w)) ? cnt_max(cnt_w) : cnt + CNT_MAX_W'(1);
    endfunction

    function automatic logic [CNT_MAX_W-1:0] sat_dec(input logic [CNT_MAX_W-1:0] cnt,
                                                     input int unsigned cnt_w);
        return (cnt == '0) ? cnt : cnt - CNT_MAX_W'(1);
    endfunction

    // Weakly not-taken: one below the taken threshold.
    function automatic logic [CNT_MAX_W-1:0] cnt_reset(input int unsigned cnt_w);
        return CNT_MAX_W'((64'd1 << (cnt_w - 1)) - 64'd1);
    endfunction

endpackage

// File: rtl/bp_sat_counter_array.sv
// Pattern history table: saturating counters with one combinational direction read
// and one read-modify-write training port.
module bp_sat_counter_array
    import bp_pkg::*;
#(
    parameter int ENTRIES = 256,
    parameter int CNT_W   = 2,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_taken,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_taken
);

    localparam logic [CNT_W-1:0] CNT_RST = CNT_W'(cnt_reset(CNT_W));

    logic [CNT_W-1:0] cnt_q [ENTRIES];
    logic [CNT_W-1:0] cnt_d [ENTRIES];

    // Training reads the live table entry, not the value seen at fetch time.
    always_comb begin
        cnt_d = cnt_q;
        if (wr_en) begin
            cnt_d[wr_idx] = wr_taken ? CNT_W'(sat_inc(CNT_MAX_W'(cnt_q[wr_idx]), CNT_W))
                                     : CNT_W'(sat_dec(CNT_MAX_W'(cnt_q[wr_idx]), CNT_W));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= CNT_RST;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign rd_taken = cnt_q[rd_idx][CNT_W-1];

endmodule

// File: rtl/bp_gshare_btb.sv
// IF-stage branch predictor: tagged direct-mapped BTB plus bimodal/gshare PHT,
// trained non-speculatively from ID-stage resolution, with saturating perf counters.
module bp_gshare_btb
    import bp_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int BTB_ENTRIES = 64,
    parameter int PHT_ENTRIES = 256,
    parameter int CNT_W       = 2,
    parameter int GHR_W       = 8,
    parameter int MODE        = 1,
    parameter int PERF_W      = 32,
    parameter int BTB_IDX_W   = $clog2(BTB_ENTRIES),
    parameter int PHT_IDX_W   = $clog2(PHT_ENTRIES),
    parameter int TAG_W       = XLEN - BTB_IDX_W - 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [XLEN-1:0]      fetch_pc,
    output logic                 pred_taken,
    output logic [XLEN-1:0]      pred_target,
    output logic                 pred_hit,
    output logic [PHT_IDX_W-1:0] pred_pht_idx,
    input  logic                 upd_en,
    input  logic [XLEN-1:0]      upd_pc,
    input  logic                 upd_taken,
    input  logic [XLEN-1:0]      upd_target,
    input  logic [PHT_IDX_W-1:0] upd_pht_idx,
    input  logic                 upd_mispred,
    output logic [GHR_W-1:0]     ghr,
    output logic [PERF_W-1:0]    br_count,
    output logic [PERF_W-1:0]    mispred_count
);

    logic                 valid_q [BTB_ENTRIES];
    logic                 valid_d [BTB_ENTRIES];
    logic [TAG_W-1:0]     tag_q   [BTB_ENTRIES];
    logic [TAG_W-1:0]     tag_d   [BTB_ENTRIES];
    logic [XLEN-1:0]      tgt_q   [BTB_ENTRIES];
    logic [XLEN-1:0]      tgt_d   [BTB_ENTRIES];
    logic [GHR_W-1:0]     ghr_q, ghr_d;
    logic [PERF_W-1:0]    br_q, br_d, mis_q, mis_d;

    logic [BTB_IDX_W-1:0] f_btb_idx, u_btb_idx;
    logic [PHT_IDX_W-1:0] pc_idx;
    btb_entry_t           btb_rd;
    logic                 pht_taken;
    logic                 unused_upd_pc;

    assign f_btb_idx     = fetch_pc[BTB_IDX_W+1:2];
    assign u_btb_idx     = upd_pc[BTB_IDX_W+1:2];
    assign pc_idx        = fetch_pc[PHT_IDX_W+1:2];
    assign unused_upd_pc = ^upd_pc[1:0];

    always_comb begin
        btb_rd.valid  = valid_q[f_btb_idx];
        btb_rd.tag    = BP_XLEN'(tag_q[f_btb_idx]);
        btb_rd.target = BP_XLEN'(tgt_q[f_btb_idx]);
    end

    assign pred_hit     = btb_rd.valid && (btb_rd.tag == BP_XLEN'(fetch_pc[XLEN-1:BTB_IDX_W+2]));
    assign pred_pht_idx = (MODE != 0) ? (pc_idx ^ PHT_IDX_W'(ghr_q)) : pc_idx;
    assign pred_taken   = pred_hit && pht_taken;
    assign pred_target  = pred_taken ? btb_rd.target[XLEN-1:0] : fetch_pc + XLEN'(4);

    bp_sat_counter_array #(
        .ENTRIES (PHT_ENTRIES),
        .CNT_W   (CNT_W),
        .IDX_W   (PHT_IDX_W)
    ) u_pht (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (pred_pht_idx),
        .rd_taken (pht_taken),
        .wr_en    (upd_en),
        .wr_idx   (upd_pht_idx),
        .wr_taken (upd_taken)
    );

    // Only taken branches allocate; not-taken never touches the BTB.
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        tgt_d   = tgt_q;
        ghr_d   = ghr_q;
        br_d    = br_q;
        mis_d   = mis_q;
        if (upd_en) begin
            if (upd_taken) begin
                valid_d[u_btb_idx] = 1'b1;
                tag_d[u_btb_idx]   = upd_pc[XLEN-1:BTB_IDX_W+2];
                tgt_d[u_btb_idx]   = upd_target;
            end
            ghr_d = (ghr_q << 1) | GHR_W'(upd_taken);
            br_d  = (br_q == '1) ? br_q : br_q + PERF_W'(1);
            if (upd_mispred) mis_d = (mis_q == '1) ? mis_q : mis_q + PERF_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BTB_ENTRIES; i++) valid_q[i] <= 1'b0;
            ghr_q <= '0;
            br_q  <= '0;
            mis_q <= '0;
        end else begin
            valid_q <= valid_d;
            ghr_q   <= ghr_d;
            br_q    <= br_d;
            mis_q   <= mis_d;
        end
    end

    // Tag/target payload is qualified by valid, so it needs no reset.
    always_ff @(posedge clk) begin
        tag_q <= tag_d;
        tgt_q <= tgt_d;
    end

    assign ghr           = ghr_q;
    assign br_count      = br_q;
    assign mispred_count = mis_q;

endmodule

// File: tb/tb_bp_gshare_btb.sv
// Directed bench: bimodal instance (4-entry BTB, 4-bit perf) and gshare instance (GHR_W=2).
module tb_bp_gshare_btb;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [31:0] a_fetch_pc, a_pred_target, a_upd_pc, a_upd_target;
    logic        a_pred_taken, a_pred_hit, a_upd_en, a_upd_taken, a_upd_mispred;
    logic [7:0]  a_pred_pht_idx, a_upd_pht_idx, a_ghr;
    logic [3:0]  a_br, a_mis;

    logic [31:0] b_fetch_pc, b_pred_target, b_upd_pc, b_upd_target, b_br, b_mis;
    logic        b_pred_taken, b_pred_hit, b_upd_en, b_upd_taken, b_upd_mispred;
    logic [7:0]  b_pred_pht_idx, b_upd_pht_idx;
    logic [1:0]  b_ghr;

    bp_gshare_btb #(
        .XLEN(32), .BTB_ENTRIES(4), .PHT_ENTRIES(256), .CNT_W(2),
        .GHR_W(8), .MODE(0), .PERF_W(4)
    ) dut_a (
        .clk(clk), .rst(rst), .fetch_pc(a_fetch_pc),
        .pred_taken(a_pred_taken), .pred_target(a_pred_target), .pred_hit(a_pred_hit),
        .pred_pht_idx(a_pred_pht_idx), .upd_en(a_upd_en), .upd_pc(a_upd_pc),
        .upd_taken(a_upd_taken), .upd_target(a_upd_target), .upd_pht_idx(a_upd_pht_idx),
        .upd_mispred(a_upd_mispred), .ghr(a_ghr), .br_count(a_br), .mispred_count(a_mis)
    );

    bp_gshare_btb #(
        .XLEN(32), .BTB_ENTRIES(64), .PHT_ENTRIES(256), .CNT_W(2),
        .GHR_W(2), .MODE(1), .PERF_W(32)
    ) dut_b (
        .clk(clk), .rst(rst), .fetch_pc(b_fetch_pc),
        .pred_taken(b_pred_taken), .pred_target(b_pred_target), .pred_hit(b_pred_hit),
        .pred_pht_idx(b_pred_pht_idx), .upd_en(b_upd_en), .upd_pc(b_upd_pc),
        .upd_taken(b_upd_taken), .upd_target(b_upd_target), .upd_pht_idx(b_upd_pht_idx),
        .upd_mispred(b_upd_mispred), .ghr(b_ghr), .br_count(b_br), .mispred_count(b_mis)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Entered and left at posedge+1; the update lands on the enclosed posedge.
    task automatic upd_a(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                         input logic [7:0] idx, input logic mis);
        a_upd_pc = pc; a_upd_taken = tk; a_upd_target = tgt;
        a_upd_pht_idx = idx; a_upd_mispred = mis; a_upd_en = 1'b1;
        @(posedge clk); #1;
        a_upd_en = 1'b0;
    endtask

    task automatic upd_b(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                         input logic [7:0] idx);
        b_upd_pc = pc; b_upd_taken = tk; b_upd_target = tgt;
        b_upd_pht_idx = idx; b_upd_mispred = 1'b0; b_upd_en = 1'b1;
        @(posedge clk); #1;
        b_upd_en = 1'b0;
    endtask

    initial begin
        logic [31:0] pc;
        logic        o;
        logic [7:0]  eidx;

        a_fetch_pc = 32'h0; a_upd_en = 0; a_upd_pc = 0; a_upd_taken = 0;
        a_upd_target = 0; a_upd_pht_idx = 0; a_upd_mispred = 0;
        b_fetch_pc = 32'h0; b_upd_en = 0; b_upd_pc = 0; b_upd_taken = 0;
        b_upd_target = 0; b_upd_pht_idx = 0; b_upd_mispred = 0;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Post-reset state
        a_fetch_pc = 32'h100; #1;
        chk("rst0_taken", 32'(a_pred_taken), 32'd0);
        chk("rst0_target", a_pred_target, 32'h104);
        chk("rst0_br", 32'(a_br), 32'd0);
        @(posedge clk); #1;

        // Bimodal training at 0x100 -> 0x80 (PHT idx 0x40)
        upd_a(32'h100, 1'b1, 32'h80, 8'h40, 1'b0);
        upd_a(32'h100, 1'b1, 32'h80, 8'h40, 1'b0);
        a_fetch_pc = 32'h100; #1;
        chk("trn_hit", 32'(a_pred_hit), 32'd1);
        chk("trn_taken", 32'(a_pred_taken), 32'd1);
        chk("trn_target", a_pred_target, 32'h80);
        chk("trn_idx", 32'(a_pred_pht_idx), 32'h40);
        for (int i = 0; i < 3; i++) upd_a(32'h100, 1'b0, 32'h0, 8'h40, 1'b1);
        #1;
        chk("nt3_taken", 32'(a_pred_taken), 32'd0);
        chk("nt3_target", a_pred_target, 32'h104);
        chk("nt3_hit", 32'(a_pred_hit), 32'd1);
        upd_a(32'h100, 1'b0, 32'h0, 8'h40, 1'b0);
        upd_a(32'h100, 1'b1, 32'h80, 8'h40, 1'b0);
        #1;
        chk("floor_taken", 32'(a_pred_taken), 32'd0);
        upd_a(32'h100, 1'b1, 32'h80, 8'h40, 1'b0);
        #1;
        chk("recover_taken", 32'(a_pred_taken), 32'd1);
        chk("trn_ghr", 32'(a_ghr), 32'hC3);

        // Alias: 0x10 and 0x20 share BTB index 0
        upd_a(32'h10, 1'b1, 32'h200, 8'h04, 1'b0);
        upd_a(32'h20, 1'b1, 32'h300, 8'h08, 1'b0);
        a_fetch_pc = 32'h10; #1;
        chk("alias_10_hit", 32'(a_pred_hit), 32'd0);
        a_fetch_pc = 32'h20; #1;
        chk("alias_20_hit", 32'(a_pred_hit), 32'd1);
        chk("alias_20_taken", 32'(a_pred_taken), 32'd1);
        chk("alias_20_target", a_pred_target, 32'h300);
        a_fetch_pc = 32'h100; #1;
        chk("alias_100_hit", 32'(a_pred_hit), 32'd0);

        // Same-cycle predict and update of one entry
        @(posedge clk); #1;
        a_fetch_pc = 32'h28;
        a_upd_pc = 32'h28; a_upd_taken = 1'b1; a_upd_target = 32'h500;
        a_upd_pht_idx = 8'h0A; a_upd_mispred = 1'b0; a_upd_en = 1'b1;
        #1;
        chk("same_old_hit", 32'(a_pred_hit), 32'd0);
        chk("same_old_taken", 32'(a_pred_taken), 32'd0);
        chk("same_old_target", a_pred_target, 32'h2C);
        @(posedge clk); #1;
        a_upd_en = 1'b0; #1;
        chk("same_new_hit", 32'(a_pred_hit), 32'd1);
        chk("same_new_taken", 32'(a_pred_taken), 32'd1);
        chk("same_new_target", a_pred_target, 32'h500);
        chk("a_ghr", 32'(a_ghr), 32'h1F);
        chk("a_br", 32'(a_br), 32'd11);
        chk("a_mis", 32'(a_mis), 32'd3);

        // Gshare: alternating T/N at 0x40 (pc_idx 0x10)
        @(posedge clk); #1;
        b_fetch_pc = 32'h40;
        for (int k = 0; k < 20; k++) begin
            o    = (k % 2 == 0);
            eidx = (k == 0) ? 8'h10 : ((k % 2 == 1) ? 8'h11 : 8'h12);
            #1;
            if (k < 2) chk($sformatf("gs_idx_k%0d", k), 32'(b_pred_pht_idx), 32'(eidx));
            if (k >= 12) begin
                chk($sformatf("gs_taken_k%0d", k), 32'(b_pred_taken), 32'(o));
                chk($sformatf("gs_idx_k%0d", k), 32'(b_pred_pht_idx), 32'(eidx));
                chk($sformatf("gs_target_k%0d", k), b_pred_target, o ? 32'h800 : 32'h44);
            end
            upd_b(32'h40, o, 32'h800, eidx);
        end
        chk("gs_ghr", 32'(b_ghr), 32'h2);

        // Reset asserted mid-update discards the update
        @(posedge clk); #1;
        a_upd_pc = 32'h100; a_upd_taken = 1'b1; a_upd_target = 32'h80;
        a_upd_pht_idx = 8'h40; a_upd_mispred = 1'b1; a_upd_en = 1'b1;
        #2 rst = 1'b1;
        @(posedge clk); #1;
        a_upd_en = 1'b0;
        #1 rst = 1'b0;
        a_fetch_pc = 32'h100; #1;
        chk("rst_disc_hit", 32'(a_pred_hit), 32'd0);
        a_fetch_pc = 32'h20; #1;
        chk("rst_20_hit", 32'(a_pred_hit), 32'd0);
        for (int i = 0; i < 16; i++) begin
            pc = 32'hFFFF_FFC0 + 32'(i * 4);
            a_fetch_pc = pc; #1;
            chk($sformatf("sweep_taken_%0d", i), 32'(a_pred_taken), 32'd0);
            chk($sformatf("sweep_target_%0d", i), a_pred_target, pc + 32'd4);
        end
        chk("rst_a_ghr", 32'(a_ghr), 32'd0);
        chk("rst_a_br", 32'(a_br), 32'd0);
        chk("rst_a_mis", 32'(a_mis), 32'd0);
        chk("rst_b_ghr", 32'(b_ghr), 32'd0);
        chk("rst_b_br", b_br, 32'd0);

        // Perf counters saturate at 4'hF
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) upd_a(32'h300, 1'b0, 32'h0, 8'hC0, 1'b1);
        chk("perf3_br", 32'(a_br), 32'd3);
        chk("perf3_mis", 32'(a_mis), 32'd3);
        for (int i = 0; i < 17; i++) upd_a(32'h300, 1'b0, 32'h0, 8'hC0, 1'b1);
        chk("perf20_br", 32'(a_br), 32'hF);
        chk("perf20_mis", 32'(a_mis), 32'hF);
        upd_a(32'h300, 1'b0, 32'h0, 8'hC0, 1'b0);
        chk("perf_hold_br", 32'(a_br), 32'hF);
        chk("perf_hold_mis", 32'(a_mis), 32'hF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
